wb_mem_copy: RTL and testbench

- Wishbone classic master that copies a block of 32-bit words from one word address range to another.
- Sits directly upstream of the on-chip Wishbone memory slave and drives its bus. Software or a control FSM triggers it through a start/length command port.
- Used for boot-time relocation and block-fill tests.
- Performs one read then one write per word, using single-beat classic cycles only.

---
 rtl/wb_mem_copy.sv | 213 +++++++++++++++++++++
 tb/tb_wb_mem_copy.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_copy.sv
// +----------------------------------------------------------------------------+
// | wb_mem_copy                                                                |
// | Wishbone classic master copying a block of 32-bit words, read-then-write.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module wb_mem_copy #(
  parameter int TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [29:0] src_adr,
  input  logic [29:0] dst_adr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done,
  output logic [29:0] bus_adr,
  output logic [31:0] bus_dat_w,
  input  logic [31:0] bus_dat_r,
  output logic [3:0]  bus_sel,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [2:0]  bus_cti,
  output logic [1:0]  bus_bte,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [9:0] c_tmo_last = 10'(TIMEOUT - 1);
  localparam logic [3:0] c_sel_all  = 4'hF;

  state_e      state_q, state_d;
  logic [29:0] src_q, src_d;
  logic [29:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] words_q, words_d;
  logic [31:0] data_q, data_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_w_q, dat_w_d;
  logic [3:0]  sel_q, sel_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;

  logic [29:0] w_src_adr;
  logic [29:0] w_dst_adr;
  logic        w_last;

  // Word index doubles as the completed-word count; address sums wrap at 2^30.
  assign w_src_adr = src_q + {14'd0, words_q};
  assign w_dst_adr = dst_q + {14'd0, words_q};
  assign w_last    = (({1'b0, words_q} + 17'd1) == {1'b0, len_q});

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      words_q <= words_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    words_d = words_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q & ~done_q;
    done_d  = 1'b0;
    error_d = error_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;

    case (state_q)
      S_IDLE: begin
        // busy_q still covers the done cycle, so a start there is dropped.
        if (start && !busy_q) begin
          src_d   = src_adr;
          dst_d   = dst_adr;
          len_d   = length;
          words_d = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (length == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RD;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = c_sel_all;
            adr_d   = src_adr;
            cnt_d   = '0;
          end
        end
      end

      S_RD, S_WR: begin
        if (!cyc_q) begin
          // Idle gap cycle after the previous access: issue the next request.
          cyc_d = 1'b1;
          stb_d = 1'b1;
          sel_d = c_sel_all;
          cnt_d = '0;
          we_d  = (state_q == S_WR);
          adr_d = (state_q == S_WR) ? w_dst_adr : w_src_adr;
          if (state_q == S_WR) begin
            dat_w_d = data_q;
          end
        end else if (bus_err || (!bus_ack && (cnt_q == c_tmo_last))) begin
          error_d = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          state_d = S_DONE;
        end else if (bus_ack) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = '0;
          if (state_q == S_RD) begin
            data_d  = bus_dat_r;
            state_d = S_WR;
          end else begin
            words_d = words_q + 16'd1;
            state_d = w_last ? S_DONE : S_RD;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = words_q;
  assign bus_adr    = adr_q;
  assign bus_dat_w  = dat_w_q;
  assign bus_sel    = sel_q;
  assign bus_cyc    = cyc_q;
  assign bus_stb    = stb_q;
  assign bus_we     = we_q;
  assign bus_cti    = 3'b000;
  assign bus_bte    = 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_copy.sv
// +----------------------------------------------------------------------------+
// | tb_wb_mem_copy                                                             |
// | Scoreboard bench: memory slave, reference copy model, access/done monitor. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_wb_mem_copy;

  localparam int TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [29:0] src_adr = '0;
  logic [29:0] dst_adr = '0;
  logic [15:0] length  = '0;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic [29:0] bus_adr;
  logic [31:0] bus_dat_w;
  logic [31:0] bus_dat_r = '0;
  logic [3:0]  bus_sel;
  logic        bus_cyc, bus_stb, bus_we;
  logic [2:0]  bus_cti;
  logic [1:0]  bus_bte;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;

  always #5 sys_clk = ~sys_clk;

  wb_mem_copy #(.TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .src_adr   (src_adr),
    .dst_adr   (dst_adr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .words_done(words_done),
    .bus_adr   (bus_adr),
    .bus_dat_w (bus_dat_w),
    .bus_dat_r (bus_dat_r),
    .bus_sel   (bus_sel),
    .bus_cyc   (bus_cyc),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_cti   (bus_cti),
    .bus_bte   (bus_bte),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  typedef struct {
    bit          we;
    logic [29:0] adr;
    logic [31:0] dat;
    int          dur;
  } acc_t;

  typedef struct {
    int wd;
    bit er;
    int t0;
    int dcyc;
  } done_t;

  acc_t        exp_acc[$];
  done_t       exp_done[$];
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  bit          noack   = 1'b0;
  bit          err_en  = 1'b0;
  bit          err_ack = 1'b0;
  logic [29:0] err_adr = '0;

  always @(posedge sys_clk) edge_n <= edge_n + 1;

  function automatic logic [31:0] dflt(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory slave: answers in the same cycle the strobe is seen.
  always @(negedge sys_clk) begin
    bus_ack = 1'b0;
    bus_err = 1'b0;
    if (!sys_rst && bus_cyc && bus_stb && !noack) begin
      if (bus_we && err_en && bus_adr == err_adr) begin
        bus_err = 1'b1;
        bus_ack = err_ack;
      end else begin
        bus_ack = 1'b1;
        if (bus_we) mem[bus_adr] = bus_dat_w;
        else        bus_dat_r = mem_rd(bus_adr);
      end
    end
  end

  // Monitor: pops the scoreboard on every new request and every done pulse.
  bit    prev_req  = 1'b0;
  bit    req       = 1'b0;
  bit    in_req    = 1'b0;
  bit    chk_after = 1'b0;
  int    dur       = 0;
  acc_t  cur;
  done_t de;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_req  = 1'b0;
      in_req    = 1'b0;
      chk_after = 1'b0;
    end else begin
      req = bus_cyc && bus_stb;
      if (chk_after) begin
        chk("done_one_cycle", done, 1'b0);
        chk("busy_falls", busy, 1'b0);
        chk_after = 1'b0;
      end
      if (req && !prev_req) begin
        if (exp_acc.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_access: adr 0x%0h we %0b, expected no access", bus_adr, bus_we);
        end else begin
          cur    = exp_acc.pop_front();
          in_req = 1'b1;
          dur    = 0;
          chk("acc_we", bus_we, cur.we);
          chk("acc_adr", bus_adr, cur.adr);
          chk("acc_sel", bus_sel, 4'hF);
          if (cur.we) chk("acc_wdata", bus_dat_w, cur.dat);
        end
      end
      if (req) dur++;
      if (!req && prev_req && in_req) begin
        chk("acc_stb_cycles", dur, cur.dur);
        in_req = 1'b0;
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done=1, expected 0");
        end else begin
          de = exp_done.pop_front();
          chk("done_cycle", edge_n - de.t0 + 1, de.dcyc);
          chk("words_done", words_done, de.wd);
          chk("error", error, de.er);
          chk("busy_at_done", busy, 1'b1);
          chk("accesses_left", exp_acc.size(), 0);
          chk_after = 1'b1;
        end
      end
      prev_req = req;
    end
  end

  // mode 0: normal, 1: err on write of word k, 2: slave never responds.
  task automatic issue_cmd(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n,
                           input int mode, input int k);
    int          nn;
    int          wd;
    bit          er;
    int          dcyc;
    logic [29:0] a, b;
    logic [31:0] v;
    acc_t        e;
    done_t       dn;
    nn      = int'(n);
    noack   = (mode == 2);
    err_en  = (mode == 1);
    err_adr = d + 30'(k);
    err_ack = 1'($urandom_range(0, 1));
    wd      = 0;
    er      = 1'b0;
    dcyc    = 4 * nn + 1;
    if (mode == 2) begin
      if (nn != 0) begin
        e.we = 1'b0; e.adr = s; e.dat = '0; e.dur = TIMEOUT;
        exp_acc.push_back(e);
        er   = 1'b1;
        dcyc = TIMEOUT + 2;
      end
    end else begin
      for (int i = 0; i < nn; i++) begin
        a = s + 30'(i);
        b = d + 30'(i);
        v = ref_rd(a);
        e.we = 1'b0; e.adr = a; e.dat = '0; e.dur = 1;
        exp_acc.push_back(e);
        e.we = 1'b1; e.adr = b; e.dat = v; e.dur = 1;
        exp_acc.push_back(e);
        if (mode == 1 && i == k) begin
          er   = 1'b1;
          dcyc = 4 * i + 5;
          break;
        end
        ref_mem[b] = v;
        wd++;
      end
    end
    dn.wd = wd; dn.er = er; dn.t0 = edge_n + 1; dn.dcyc = dcyc;
    exp_done.push_back(dn);
    start   = 1'b1;
    src_adr = s;
    dst_adr = d;
    length  = n;
    @(negedge sys_clk);
    start   = 1'b0;
    src_adr = 30'($urandom);
    dst_adr = 30'($urandom);
    length  = 16'($urandom);
    chk("error_cleared_on_start", error, 1'b0);
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_cmd();
    for (int c = 0; c < 2000 && exp_done.size() != 0; c++) @(negedge sys_clk);
    if (exp_done.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL cmd_timeout: done not seen, %0d commands outstanding", exp_done.size());
      exp_done.delete();
      exp_acc.delete();
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic run_cmd(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n,
                         input int mode, input int k);
    issue_cmd(s, d, n, mode, k);
    wait_cmd();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_words_done"}, words_done, 16'd0);
    chk({tag, "_cyc"}, bus_cyc, 1'b0);
    chk({tag, "_stb"}, bus_stb, 1'b0);
    chk({tag, "_we"}, bus_we, 1'b0);
    chk({tag, "_sel"}, bus_sel, 4'h0);
    chk({tag, "_adr"}, bus_adr, 30'd0);
    chk({tag, "_dat_w"}, bus_dat_w, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] s, d;
    logic [15:0] n;
    logic [31:0] v;
    int          mode, k;
    bit          found;

    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("cti_const", bus_cti, 3'b000);
    chk("bte_const", bus_bte, 2'b00);

    // Basic three-word copy.
    mem[30'h10] = 32'h1111_1111; ref_mem[30'h10] = 32'h1111_1111;
    mem[30'h11] = 32'h2222_2222; ref_mem[30'h11] = 32'h2222_2222;
    mem[30'h12] = 32'h3333_3333; ref_mem[30'h12] = 32'h3333_3333;
    run_cmd(30'h10, 30'h40, 16'd3, 0, 0);
    chk("dst_word0", mem_rd(30'h40), 32'h1111_1111);
    chk("dst_word1", mem_rd(30'h41), 32'h2222_2222);
    chk("dst_word2", mem_rd(30'h42), 32'h3333_3333);

    run_cmd(30'h100, 30'h200, 16'd0, 0, 0);
    run_cmd(30'h300, 30'h380, 16'd4, 1, 1);
    chk("no_write_word2", mem_rd(30'h382), dflt(30'h382));

    run_cmd(30'h400, 30'h480, 16'd3, 2, 0);
    chk("error_sticky", error, 1'b1);
    run_cmd(30'h500, 30'h580, 16'd2, 0, 0);

    run_cmd(30'h3FFF_FFFF, 30'h600, 16'd2, 0, 0);

    // Async reset during the second write; an ignored start arrives first.
    issue_cmd(30'h2000, 30'h3000, 16'd6, 0, 0);
    @(negedge sys_clk);
    start   = 1'b1;
    src_adr = 30'h0123;
    dst_adr = 30'h0456;
    length  = 16'd9;
    @(negedge sys_clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge sys_clk);
      if (bus_cyc && bus_stb && bus_we && words_done == 16'd1) found = 1'b1;
    end
    chk("reached_second_write", found, 1'b1);
    #2 sys_rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    exp_acc.delete();
    exp_done.delete();
    ref_mem = mem;
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Randomized commands, including overlap, address wrap and error injection.
    for (int t = 0; t < 10; t++) begin
      n = 16'($urandom_range(1, 10));
      case ($urandom_range(0, 2))
        0:       s = 30'($urandom);
        1:       s = 30'h3FFF_FFF8 + 30'($urandom_range(0, 7));
        default: s = 30'h8000 + 30'($urandom_range(0, 31));
      endcase
      d = ($urandom_range(0, 1) == 1) ? s + 30'($urandom_range(1, 3)) : 30'($urandom);
      for (int i = 0; i < int'(n); i++) begin
        v = $urandom;
        mem[s + 30'(i)]     = v;
        ref_mem[s + 30'(i)] = v;
      end
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      k    = $urandom_range(0, int'(n) - 1);
      run_cmd(s, d, n, mode, k);
    end

    run_cmd(30'h700, 30'h780, 16'd1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
